pattern_scan_ctrl: RTL and testbench

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Serial pattern scanner. Each accepted byte is shifted MSB first, one bit per
//   cycle, into an 8-bit history register. After each bit the low cfg_len history
//   bits are compared against the configured pattern. The FSM runs
//   IDLE -> SHIFT (8 cycles) -> DONE (1 cycle) -> IDLE, so one byte takes 10 cycles.
//   History and fill count carry over from one byte to the next, so a pattern
//   can span a byte boundary.
//
// Optional feature (macro SCAN_IRQ_EN): adds a sticky irq output and an
// irq_clr input. If both a hit and irq_clr occur in the same cycle, the set wins.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   cfg_we          config write strobe (honoured in IDLE only)
//   cfg_pat[7:0]    pattern, LSB = last-received bit
//   cfg_len[3:0]    pattern length 1..8 (0 or >8 is stored as 8)
//   cfg_ovl         1 = overlapping detection, 0 = non-overlapping
//   in_valid/in_data/in_ready  byte handshake
//   clr_cnt         synchronous hit-counter clear (wins over an increment)
//   hit             one-cycle registered match pulse
//   hit_cnt[15:0]   saturating hit counter
//   busy, done      FSM status (done is high for the single DONE cycle)
//   irq, irq_clr    SCAN_IRQ_EN builds only
module pattern_scan_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [7:0]  cfg_pat,
  input  logic [3:0]  cfg_len,
  input  logic        cfg_ovl,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        clr_cnt,
  output logic        hit,
  output logic [15:0] hit_cnt,
  output logic        busy,
  output logic        done
`ifdef SCAN_IRQ_EN
  ,
  output logic        irq,
  input  logic        irq_clr
`endif
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q;
  logic [7:0]  byte_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  hist_q;
  logic [3:0]  fill_q;
  logic [7:0]  pat_q;
  logic [3:0]  len_q;
  logic        ovl_q;
  logic        hit_q;
  logic [15:0] cnt_q;
  logic        busy_q;
  logic        done_q;

  logic        shift_bit;
  logic [7:0]  hist_d;
  logic [3:0]  fill_inc;
  logic [7:0]  len_mask;
  logic [3:0]  len_fix;
  logic        match;

  always_comb begin
    shift_bit = byte_q[3'd7 - bit_cnt_q];
    hist_d    = {hist_q[6:0], shift_bit};
    fill_inc  = (fill_q == 4'd8) ? 4'd8 : fill_q + 4'd1;
    // len_q is always 1..8, so the shift amount is 0..7
    len_mask  = 8'hFF >> (4'd8 - len_q);
    len_fix   = ((cfg_len == 4'd0) || (cfg_len > 4'd8)) ? 4'd8 : cfg_len;
    // Compare against the history as it will be after this cycle's bit lands
    match     = (state_q == StShift) && (fill_inc >= len_q) &&
                (((hist_d ^ pat_q) & len_mask) == 8'h00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      byte_q    <= 8'h00;
      bit_cnt_q <= 3'd0;
      hist_q    <= 8'h00;
      fill_q    <= 4'd0;
      pat_q     <= 8'h2B;
      len_q     <= 4'd6;
      ovl_q     <= 1'b1;
      hit_q     <= 1'b0;
      cnt_q     <= 16'h0000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      hit_q <= 1'b0;

      if (clr_cnt) begin
        cnt_q <= 16'h0000;
      end else if (match && (cnt_q != 16'hFFFF)) begin
        cnt_q <= cnt_q + 16'd1;
      end

      unique case (state_q)
        StIdle: begin
          // A config write lands in the same edge as a byte accept, so the
          // byte is scanned against the new config from a cleared history.
          if (cfg_we) begin
            pat_q  <= cfg_pat;
            len_q  <= len_fix;
            ovl_q  <= cfg_ovl;
            hist_q <= 8'h00;
            fill_q <= 4'd0;
          end
          if (in_valid) begin
            byte_q    <= in_data;
            bit_cnt_q <= 3'd0;
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          hist_q    <= hist_d;
          // Non-overlap: forget the bits that formed this match
          fill_q    <= (match && !ovl_q) ? 4'd0 : fill_inc;
          hit_q     <= match;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SCAN_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (match) begin
      irq_q <= 1'b1;
    end else if (irq_clr) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

  // Held low while reset is asserted, high in IDLE afterwards
  assign in_ready = (state_q == StIdle) && !rst;
  assign hit      = hit_q;
  assign hit_cnt  = cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl. A bit-level reference model
// computes, for every byte driven, the expected per-bit hit vector and the
// expected hit_cnt; these are pushed to a scoreboard queue and popped when the
// DUT reaches DONE for that byte.
module tb_pattern_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [7:0]  cfg_pat;
  logic [3:0]  cfg_len;
  logic        cfg_ovl;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        clr_cnt;
  logic        hit;
  logic [15:0] hit_cnt;
  logic        busy;
  logic        done;
  logic        irq;
  logic        irq_clr;

  always #5 clk = ~clk;

  pattern_scan_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_we   (cfg_we),
    .cfg_pat  (cfg_pat),
    .cfg_len  (cfg_len),
    .cfg_ovl  (cfg_ovl),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .clr_cnt  (clr_cnt),
    .hit      (hit),
    .hit_cnt  (hit_cnt),
    .busy     (busy),
    .done     (done)
`ifdef SCAN_IRQ_EN
    ,
    .irq      (irq),
    .irq_clr  (irq_clr)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  m_hist;
  int          m_fill;
  logic [7:0]  m_pat;
  int          m_len;
  logic        m_ovl;
  int          m_cnt;
  logic        m_irq;

  typedef struct {
    logic [7:0]  hits;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  task automatic m_reset();
    m_hist = 8'h00; m_fill = 0; m_pat = 8'h2B; m_len = 6; m_ovl = 1'b1;
    m_cnt = 0; m_irq = 1'b0;
  endtask

  task automatic m_config(input logic [7:0] p, input logic [3:0] l, input logic o);
    m_pat  = p;
    m_len  = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
    m_ovl  = o;
    m_hist = 8'h00;
    m_fill = 0;
  endtask

  function automatic logic model_bit(input logic b, input logic clr);
    logic [7:0] mask;
    logic       m;
    m_hist = {m_hist[6:0], b};
    m_fill = (m_fill >= 8) ? 8 : m_fill + 1;
    mask   = 8'hFF >> (8 - m_len);
    m      = (m_fill >= m_len) && ((m_hist & mask) == (m_pat & mask));
    if (m && !m_ovl) m_fill = 0;
    if (clr) m_cnt = 0;
    else if (m && m_cnt < 65535) m_cnt = m_cnt + 1;
    if (m) m_irq = 1'b1;
    else if (clr) m_irq = 1'b0;
    return m;
  endfunction

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  // clr_at/cfg_at: SHIFT/DONE sample index at which clr_cnt (and irq_clr) or a
  // junk cfg_we is driven; -1 = never.
  task automatic send_byte(input logic [7:0] b, input logic we, input logic [7:0] p,
                           input logic [3:0] l, input logic o, input int clr_at,
                           input int cfg_at);
    exp_t e;
    logic [7:0] obs;
    if (we) m_config(p, l, o);
    for (int k = 0; k < 8; k++) e.hits[k] = model_bit(b[7-k], k == clr_at);
    e.cnt = m_cnt[15:0];
    sb.push_back(e);

    check_eq("ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = b;
    cfg_we = we; cfg_pat = p; cfg_len = l; cfg_ovl = o;
    @(posedge clk);
    obs = 8'h00;
    for (int s = 0; s <= 8; s++) begin
      @(negedge clk);
      if (s >= 1) obs[s-1] = hit;
      in_valid = 1'b0;
      clr_cnt  = (s == clr_at);
      irq_clr  = (s == clr_at);
      cfg_we   = (s == cfg_at);
      if (s == cfg_at) begin
        cfg_pat = 8'hFF; cfg_len = 4'd2; cfg_ovl = 1'b0;
      end
      if (s == 3) begin
        check_eq("busy_shift", {31'd0, busy}, 32'd1);
        check_eq("ready_shift", {31'd0, in_ready}, 32'd0);
        check_eq("done_shift", {31'd0, done}, 32'd0);
      end
      if (s == 8) begin
        e = sb.pop_front();
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("busy_done", {31'd0, busy}, 32'd1);
        check_eq("hit_vec", {24'd0, obs}, {24'd0, e.hits});
        check_eq("hit_cnt", {16'd0, hit_cnt}, {16'd0, e.cnt});
      end
    end
    @(negedge clk);
    clr_cnt = 1'b0; irq_clr = 1'b0; cfg_we = 1'b0;
    check_eq("done_after", {31'd0, done}, 32'd0);
    check_eq("busy_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dones;
    logic junk;
    rst = 1'b1; cfg_we = 1'b0; cfg_pat = 8'h00; cfg_len = 4'd0; cfg_ovl = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; clr_cnt = 1'b0; irq_clr = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_hit", {31'd0, hit}, 32'd0);
    check_eq("rst_cnt", {16'd0, hit_cnt}, 32'd0);
`ifdef SCAN_IRQ_EN
    check_eq("rst_irq", {31'd0, irq}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_release", {31'd0, in_ready}, 32'd1);

    // Reset config, single byte
    send_byte(8'hAC, 1'b0, 8'h00, 4'd0, 1'b0, -1, -1);
`ifdef SCAN_IRQ_EN
    check_eq("irq_set", {31'd0, irq}, 32'd1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    m_irq = 1'b0;
    check_eq("irq_clr", {31'd0, irq}, 32'd0);
`endif

    // Overlap vs non-overlap, config written in the same cycle as the byte
    send_byte(8'hAA, 1'b1, 8'h0A, 4'd4, 1'b1, -1, -1);
    send_byte(8'hAA, 1'b1, 8'h0A, 4'd4, 1'b0, -1, -1);

    // Pattern spanning a byte boundary
    send_byte(8'h02, 1'b1, 8'h2B, 4'd6, 1'b1, -1, -1);
    send_byte(8'hB0, 1'b0, 8'h00, 4'd0, 1'b0, -1, -1);

    // clr_cnt coincident with the hit-producing bit (irq_clr too)
    send_byte(8'hAC, 1'b1, 8'h2B, 4'd6, 1'b1, 5, -1);
`ifdef SCAN_IRQ_EN
    check_eq("irq_set_wins", {31'd0, irq}, {31'd0, m_irq});
`endif

    // cfg_we during SHIFT is ignored; following byte still uses old config
    send_byte(8'hAC, 1'b0, 8'h00, 4'd0, 1'b0, -1, 2);
    send_byte(8'hAC, 1'b0, 8'h00, 4'd0, 1'b0, -1, -1);

    // Length 0 is stored as 8
    send_byte(8'hA5, 1'b1, 8'hA5, 4'd0, 1'b1, -1, -1);

    // Saturation: length-1 pattern '1' on 0xFF gives 8 hits per byte
    send_byte(8'hFF, 1'b1, 8'h01, 4'd1, 1'b1, -1, -1);
    for (int i = 0; i < 8191 * 8; i++) junk = model_bit(1'b1, 1'b0);
    in_valid = 1'b1; in_data = 8'hFF;
    dones = 0;
    for (int c = 0; c < 8191 * 10 + 50 && dones < 8191; c++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 8191) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq("bulk_dones", dones, 32'd8191);
    @(negedge clk);
    check_eq("sat_cnt", {16'd0, hit_cnt}, m_cnt);
    send_byte(8'hFF, 1'b0, 8'h00, 4'd0, 1'b0, -1, -1);

    // Reset in the middle of SHIFT
    in_valid = 1'b1; in_data = 8'hAC;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("midrst_cnt", {16'd0, hit_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_eq("midrst_nodone", dones, 32'd0);
    send_byte(8'hAC, 1'b0, 8'h00, 4'd0, 1'b0, -1, -1);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
